// File: rtl/slink_bist_tx_pkg.sv
// slink_bist_tx_pkg
// Shared definitions for the S-Link BIST transmit generator: generator FSM
// states, BIST payload pattern codes (the same codes the BIST checker decodes)
// and small helpers for payload byte generation and min/max stepping.
package slink_bist_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } bist_state_t;

  localparam logic [3:0] BIST_PAYLOAD_1010      = 4'h0;
  localparam logic [3:0] BIST_PAYLOAD_1100      = 4'h1;
  localparam logic [3:0] BIST_PAYLOAD_1111_0000 = 4'h2;
  localparam logic [3:0] BIST_PAYLOAD_COUNT     = 4'h3;

  // Byte at packet offset k; anything at or past the word count is padding.
  function automatic logic [7:0] bist_payload_byte(input logic [3:0]  mode,
                                                   input logic [16:0] k,
                                                   input logic [15:0] wc);
    logic [7:0] b;
    if (k >= {1'b0, wc}) begin
      b = 8'h00;
    end else begin
      case (mode)
        BIST_PAYLOAD_1010:      b = 8'hAA;
        BIST_PAYLOAD_1100:      b = 8'hCC;
        BIST_PAYLOAD_1111_0000: b = 8'hF0;
        BIST_PAYLOAD_COUNT:     b = k[7:0];
        default:                b = 8'hD0;
      endcase
    end
    return b;
  endfunction

  // Per-packet stepping: wrap to min when max is reached, else increment.
  function automatic logic [15:0] bist_step16(input logic [15:0] cur,
                                              input logic [15:0] min_v,
                                              input logic [15:0] max_v,
                                              input logic        step_en);
    logic [15:0] nxt;
    if (!step_en)          nxt = cur;
    else if (cur == max_v) nxt = min_v;
    else                   nxt = cur + 16'd1;
    return nxt;
  endfunction

  function automatic logic [7:0] bist_step8(input logic [7:0] cur,
                                            input logic [7:0] min_v,
                                            input logic [7:0] max_v,
                                            input logic       step_en);
    logic [7:0] nxt;
    if (!step_en)          nxt = cur;
    else if (cur == max_v) nxt = min_v;
    else                   nxt = cur + 8'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/slink_bist_tx_demet_reset.sv
// slink_demet_reset
// Two-flop synchronizer for asynchronous software register bits.
// Ports: clk, reset (async, active-high), sig_in (async), sig_out (synced).
module slink_demet_reset (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_out
);

  logic sig_ff1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_ff1 <= 1'b0;
      sig_out <= 1'b0;
    end else begin
      sig_ff1 <= sig_in;
      sig_out <= sig_ff1;
    end
  end

endmodule

// File: rtl/slink_bist_tx.sv
// slink_bist_tx
// BIST packet generator for the S-Link application TX path. While enabled it
// emits back-to-back long packets whose data ID, word count and payload follow
// the programmed BIST sequence.
// Ports:
//   clk, reset (async, active-high)
//   swi_bist_*      software control (enable/reset synchronized here)
//   sop, data_id, word_count, app_data, valid   packet beat to the link layer
//   advance         link layer accepts the current beat
//   bist_active     generator is inside a packet
//   bist_pkt_count  completed packets, saturating
module slink_bist_tx
  import slink_bist_tx_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 32,
  parameter int APP_DATA_BYTES = APP_DATA_WIDTH >> 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      swi_bist_en,
  input  logic                      swi_bist_reset,
  input  logic [3:0]                swi_bist_mode_payload,
  input  logic                      swi_bist_mode_wc,
  input  logic [15:0]               swi_bist_wc_min,
  input  logic [15:0]               swi_bist_wc_max,
  input  logic                      swi_bist_mode_di,
  input  logic [7:0]                swi_bist_di_min,
  input  logic [7:0]                swi_bist_di_max,
  output logic                      sop,
  output logic [7:0]                data_id,
  output logic [15:0]               word_count,
  output logic [APP_DATA_WIDTH-1:0] app_data,
  output logic                      valid,
  input  logic                      advance,
  output logic                      bist_active,
  output logic [15:0]               bist_pkt_count
);

  localparam logic [16:0] BEAT_BYTES = 17'(APP_DATA_BYTES);

  logic        en_ff2;
  logic        rst_ff2;
  bist_state_t state;
  logic [15:0] wc_cur;
  logic [7:0]  di_cur;
  logic [16:0] byte_cnt;
  logic [15:0] pkt_cnt;
  logic [16:0] byte_cnt_nxt;
  logic        pkt_last;
  logic        xfer;

  slink_demet_reset u_demet_en (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (swi_bist_en),
    .sig_out (en_ff2)
  );

  slink_demet_reset u_demet_rst (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (swi_bist_reset),
    .sig_out (rst_ff2)
  );

  // byte_cnt is 0 in HDR, so one compare covers both the header beat and
  // payload beats; 17 bits keeps word_count=16'hFFFF from wrapping.
  assign byte_cnt_nxt = byte_cnt + BEAT_BYTES;
  assign pkt_last     = (byte_cnt_nxt >= {1'b0, wc_cur});
  assign xfer         = (state != ST_IDLE) && advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wc_cur   <= 16'd0;
      di_cur   <= 8'd0;
      byte_cnt <= 17'd0;
      pkt_cnt  <= 16'd0;
    end else begin
      if (rst_ff2)
        pkt_cnt <= 16'd0;
      else if (xfer && pkt_last && (pkt_cnt != 16'hFFFF))
        pkt_cnt <= pkt_cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (en_ff2) begin
            wc_cur   <= swi_bist_wc_min;
            di_cur   <= swi_bist_di_min;
            byte_cnt <= 17'd0;
            state    <= ST_HDR;
          end
        end
        ST_HDR, ST_PAYLOAD: begin
          if (advance) begin
            if (pkt_last) begin
              // Packets always complete; disable/restart only takes effect here.
              byte_cnt <= 17'd0;
              wc_cur   <= bist_step16(wc_cur, swi_bist_wc_min, swi_bist_wc_max, swi_bist_mode_wc);
              di_cur   <= bist_step8(di_cur, swi_bist_di_min, swi_bist_di_max, swi_bist_mode_di);
              state    <= (en_ff2 && !rst_ff2) ? ST_HDR : ST_IDLE;
            end else begin
              byte_cnt <= byte_cnt_nxt;
              state    <= ST_PAYLOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign valid          = (state != ST_IDLE);
  assign sop            = (state == ST_HDR);
  assign bist_active    = (state != ST_IDLE);
  assign data_id        = di_cur;
  assign word_count     = wc_cur;
  assign bist_pkt_count = pkt_cnt;

  always_comb begin
    app_data = '0;
    if (state != ST_IDLE) begin
      for (int i = 0; i < APP_DATA_BYTES; i++) begin
        app_data[8*i +: 8] = bist_payload_byte(swi_bist_mode_payload, byte_cnt + 17'(i), wc_cur);
      end
    end
  end

endmodule
